pb_addr_sequencer: RTL and testbench
====================================

PB_ADDR_SEQUENCER -- requirements
Module: pb_addr_sequencer

Interface
REQ-001 Parameter ADDR_W, default 15: playback address width, matching the PB_ADR PIO out_port width.
REQ-002 Parameter DATA_W, default 16: sample word width.
REQ-003 Parameter READ_LATENCY, default 2: cycles from the mem_read assertion to valid mem_readdata (range 1-4).
REQ-004 clk  in  1  sole clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 start_addr  in  ADDR_W  first sample address, driven by the PB_ADR PIO.
REQ-007 end_addr  in  ADDR_W  last sample address, inclusive.
REQ-008 go  in  1  single-cycle start request.
REQ-009 stop  in  1  single-cycle abort request.
REQ-010 loop_en  in  1  1 = wrap to start_addr after end_addr.
REQ-011 sample_tick  in  1  single-cycle sample-rate strobe.
REQ-012 mem_readdata  in  DATA_W  sample memory read data.
REQ-013 mem_address  out  ADDR_W  sample memory address.
REQ-014 mem_read  out  1  read strobe, one cycle per fetch.
REQ-015 sample_out  out  DATA_W  last fetched sample, held between fetches.
REQ-016 sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-017 busy  out  1  high whenever the FSM state is not IDLE.
REQ-018 done  out  1  one-cycle pulse on normal, non-loop completion.
REQ-019 overrun  out  1  one-cycle pulse when a sample_tick is dropped.

Function
REQ-020 The FSM SHALL have exactly the states IDLE, ARMED, READ, WAIT and DONE.
REQ-021 In IDLE, go=1 SHALL latch start_addr and end_addr into internal registers, load cur_addr with start_addr, and move to ARMED on the next cycle.
REQ-022 In ARMED, sample_tick=1 SHALL move the FSM to READ.
REQ-023 READ SHALL last exactly one cycle with mem_read=1 and mem_address=cur_addr, then move to WAIT.
REQ-024 WAIT SHALL last READ_LATENCY-1 cycles, then capture mem_readdata into sample_out and pulse sample_valid in the same cycle.
REQ-025 On capture, if cur_addr != end_addr (latched value), cur_addr SHALL increment by 1 and the FSM SHALL return to ARMED.
REQ-026 On capture, if cur_addr == end_addr and loop_en=1 (sampled at capture), cur_addr SHALL reload start_addr (latched value) and the FSM SHALL return to ARMED.
REQ-027 On capture, if cur_addr == end_addr and loop_en=0, the FSM SHALL go to DONE; DONE SHALL pulse done for one cycle, then return to IDLE.
REQ-028 If latched end_addr < start_addr, the block SHALL play start_addr only and then terminate per REQ-026/REQ-027.
REQ-029 Address arithmetic SHALL be modulo 2^ADDR_W; incrementing 0x7FFF SHALL give 0x0000.
REQ-030 stop=1 in any state SHALL force IDLE on the next cycle, with no done pulse and no sample_valid pulse; stop SHALL take priority over go, sample_tick and capture in the same cycle.
REQ-031 go while busy=1 SHALL be ignored.
REQ-032 sample_tick in READ, WAIT or DONE SHALL be dropped and SHALL pulse overrun in that cycle; sample_tick in IDLE SHALL be ignored without an overrun pulse.
REQ-033 mem_address SHALL equal cur_addr in all states.
REQ-034 mem_read SHALL be asserted only in READ.
REQ-035 All outputs SHALL be registered or decoded from registered state only, with no combinational input-to-output paths.

Reset
REQ-036 reset_n=0 SHALL asynchronously set: state=IDLE, cur_addr=0, mem_read=0, sample_out=0, sample_valid=0, done=0, overrun=0, busy=0.
REQ-037 Reset asserted mid-playback SHALL abandon the sequence; after deassertion the block SHALL wait in IDLE for a new go.

Structure
REQ-038 The FSM state encoding and the ADDR_W/DATA_W defaults SHALL live in the shared package pb_pkg.
REQ-039 The latency counter SHALL be the sub-module pb_lat_counter (load, count down, terminal-count flag); all other logic SHALL sit in a single top-level FSM.

Verification
REQ-040 start=0x0010, end=0x0012, loop_en=0, READ_LATENCY=2, tick every 8 cycles -> mem_read at addresses 0x10, 0x11, 0x12; three sample_valid pulses, each 2 cycles after its mem_read; one done pulse; busy falls after done.
REQ-041 Same as REQ-040 with loop_en=1 for 7 ticks -> address order 10,11,12,10,11,12,10; no done pulse.
REQ-042 Tick asserted in the cycle after READ -> overrun pulses once; the address sequence is unchanged.
REQ-043 stop asserted during WAIT -> next cycle state=IDLE and busy=0; no sample_valid and no done pulse; sample_out keeps its prior value.
REQ-044 start=0x7FFF, end=0x0001 -> single fetch at 0x7FFF, then done; a second run with end=0x7FFF and start=0x7FFE fetches 7FFE, 7FFF.
REQ-045 reset_n pulsed low mid-WAIT, then go -> all outputs at 0 during reset; after deassertion the new run starts cleanly from the newly latched start_addr.

Source files
------------

// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and defaults for the playback address sequencer
// Purpose: FSM state encoding, default bus widths and latency-counter sizing.
// Ports: none (package).
package pb_pkg;

  localparam int PB_ADDR_W = 15;
  localparam int PB_DATA_W = 16;
  localparam int PB_LAT_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } pb_state_t;

  // WAIT lasts READ_LATENCY-1 cycles; the counter is loaded on the READ
  // cycle and flags terminal count on the last WAIT cycle, so it starts
  // two below the latency. A latency of 1 skips WAIT entirely.
  function automatic int unsigned wait_load(input int unsigned read_latency);
    return (read_latency >= 2) ? read_latency - 2 : 0;
  endfunction

endpackage

// File: rtl/pb_addr_sequencer_if.sv
// rtl/pb_addr_sequencer_if.sv - sample memory read bus
// Purpose: groups the sample-memory read port of the sequencer.
// Signals: mem_address (ADDR_W), mem_read (1), mem_readdata (DATA_W).
// Modports: master = sequencer side, slave = memory side.
interface pb_addr_sequencer_if
  import pb_pkg::*;
#(
  parameter int ADDR_W = PB_ADDR_W,
  parameter int DATA_W = PB_DATA_W
) ();

  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic [DATA_W-1:0] mem_readdata;

  modport master (output mem_address, output mem_read, input mem_readdata);
  modport slave  (input mem_address, input mem_read, output mem_readdata);

endinterface

// File: rtl/pb_lat_counter.sv
// rtl/pb_lat_counter.sv - loadable down-counter with terminal-count flag
// Purpose: times the WAIT state of the playback sequencer.
// Ports: clk, reset_n (async, active-low), load, load_val[W], tc (count == 0).
module pb_lat_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/pb_addr_sequencer.sv
// rtl/pb_addr_sequencer.sv - sample-rate driven playback address sequencer
// Purpose: walks sample memory from start_addr to end_addr (inclusive), one
//   fetch per sample_tick, optionally looping, and presents each fetched word.
// Ports: clk, reset_n (async, active-low); start_addr/end_addr[ADDR_W];
//   go, stop, loop_en, sample_tick; mem (read bus, master);
//   sample_out[DATA_W], sample_valid, busy, done, overrun.
module pb_addr_sequencer
  import pb_pkg::*;
#(
  parameter int ADDR_W       = PB_ADDR_W,
  parameter int DATA_W       = PB_DATA_W,
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   start_addr,
  input  logic [ADDR_W-1:0]   end_addr,
  input  logic                go,
  input  logic                stop,
  input  logic                loop_en,
  input  logic                sample_tick,
  pb_addr_sequencer_if.master mem,
  output logic [DATA_W-1:0]   sample_out,
  output logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  pb_state_t         state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;
  logic              rd_q;
  logic              lat_tc;
  logic              capture;
  logic              at_end;

  pb_lat_counter #(.W(PB_LAT_W)) u_lat (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (state == ST_READ),
    .load_val (PB_LAT_W'(wait_load(READ_LATENCY))),
    .tc       (lat_tc)
  );

  assign capture = (state == ST_WAIT && lat_tc) ||
                   (state == ST_READ && READ_LATENCY == 1);

  // An inverted range plays start_addr alone, so treat it as the last word.
  assign at_end = (cur_addr == end_q) || (end_q < start_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      cur_addr     <= '0;
      start_q      <= '0;
      end_q        <= '0;
      rd_q         <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      rd_q         <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
      overrun      <= 1'b0;
      if (stop) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (go) begin
              start_q  <= start_addr;
              end_q    <= end_addr;
              cur_addr <= start_addr;
              state    <= ST_ARMED;
            end
          end
          ST_ARMED: begin
            if (sample_tick) begin
              state <= ST_READ;
              rd_q  <= 1'b1;
            end
          end
          ST_READ, ST_WAIT: begin
            overrun <= sample_tick;
            if (capture) begin
              sample_out   <= mem.mem_readdata;
              sample_valid <= 1'b1;
              if (!at_end) begin
                cur_addr <= cur_addr + ADDR_W'(1);
                state    <= ST_ARMED;
              end else if (loop_en) begin
                cur_addr <= start_q;
                state    <= ST_ARMED;
              end else begin
                state <= ST_DONE;
                done  <= 1'b1;
              end
            end else begin
              state <= ST_WAIT;
            end
          end
          ST_DONE: begin
            overrun <= sample_tick;
            state   <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy            = (state != ST_IDLE);
  assign mem.mem_address = cur_addr;
  assign mem.mem_read    = rd_q;

endmodule

// File: tb/tb_pb_addr_sequencer.sv
// tb/tb_pb_addr_sequencer.sv - self-checking bench for pb_addr_sequencer
module tb_pb_addr_sequencer;

  localparam int AW  = 15;
  localparam int DW  = 16;
  localparam int LAT = 2;

  typedef logic [AW-1:0] addr_q_t[$];

  logic          clk         = 1'b0;
  logic          reset_n     = 1'b1;
  logic [AW-1:0] start_addr  = '0;
  logic [AW-1:0] end_addr    = '0;
  logic          go          = 1'b0;
  logic          stop        = 1'b0;
  logic          loop_en     = 1'b0;
  logic          sample_tick = 1'b0;
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          busy;
  logic          done;
  logic          overrun;

  int n_tests = 0;
  int n_fail  = 0;
  int pc      = 0;

  pb_addr_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  pb_addr_sequencer #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start_addr   (start_addr),
    .end_addr     (end_addr),
    .go           (go),
    .stop         (stop),
    .loop_en      (loop_en),
    .sample_tick  (sample_tick),
    .mem          (mif),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc = pc + 1;

  // Memory model: the word for an address is only presented in the cycle
  // LAT-1 after the read strobe; any other cycle shows its complement.
  logic [DW-1:0] salt  = 16'h5A3C;
  logic          rd_d1 = 1'b0;
  always @(posedge clk) rd_d1 <= mif.mem_read;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {1'b0, a} ^ salt;
  endfunction

  assign mif.mem_readdata = rd_d1 ? mem_word(mif.mem_address) : ~mem_word(mif.mem_address);

  // Event log, sampled on the falling edge.
  int            rd_cyc[$];
  int            sv_cyc[$];
  int            done_cyc[$];
  int            ovr_cyc[$];
  logic [AW-1:0] rd_addr[$];
  logic [DW-1:0] sv_data[$];
  bit            busy_log[int];

  always @(negedge clk) begin
    busy_log[pc] = busy;
    if (mif.mem_read === 1'b1) begin
      rd_cyc.push_back(pc);
      rd_addr.push_back(mif.mem_address);
    end
    if (sample_valid === 1'b1) begin
      sv_cyc.push_back(pc);
      sv_data.push_back(sample_out);
    end
    if (done === 1'b1)    done_cyc.push_back(pc);
    if (overrun === 1'b1) ovr_cyc.push_back(pc);
  end

  task automatic clear_log();
    rd_cyc.delete(); sv_cyc.delete(); done_cyc.delete(); ovr_cyc.delete();
    rd_addr.delete(); sv_data.delete();
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1; cyc(); sample_tick = 1'b0;
  endtask

  // Reference: the playable span is start..end, or start alone when the
  // range is inverted; each tick plays the next word of the span, wrapping
  // when looping, otherwise ticks after the last word do nothing.
  function automatic addr_q_t exp_seq(input logic [AW-1:0] s, input logic [AW-1:0] e,
                                      input bit lp, input int nt, output bit exp_done);
    addr_q_t span;
    addr_q_t q;
    if (e >= s) begin
      for (int a = int'(s); a <= int'(e); a++) span.push_back(AW'(a));
    end else begin
      span.push_back(s);
    end
    for (int i = 0; i < nt; i++) begin
      if (!lp && i >= span.size()) break;
      q.push_back(span[i % span.size()]);
    end
    exp_done = !lp && (nt >= span.size());
    return q;
  endfunction

  task automatic test_playback(input string name, input logic [AW-1:0] s, input logic [AW-1:0] e,
                               input bit lp, input int nt, input int per);
    addr_q_t exp;
    bit      edone;
    int      n;
    exp = exp_seq(s, e, lp, nt, edone);
    clear_log();
    start_addr = s; end_addr = e; loop_en = lp;
    go = 1'b1; cyc(); go = 1'b0;
    start_addr = AW'($urandom); end_addr = AW'($urandom);
    for (int i = 0; i < nt; i++) begin
      cyc(per - 1);
      pulse_tick();
    end
    cyc(LAT + 4);

    n_tests++;
    if (rd_addr.size() != exp.size()) begin
      n_fail++; $display("FAIL %s fetch_count: got %0d want %0d", name, rd_addr.size(), exp.size());
    end
    n = (rd_addr.size() < exp.size()) ? rd_addr.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (rd_addr[i] !== exp[i]) begin
        n_fail++; $display("FAIL %s addr[%0d]: got %h want %h", name, i, rd_addr[i], exp[i]);
      end
    end
    n_tests++;
    if (sv_data.size() != exp.size()) begin
      n_fail++; $display("FAIL %s valid_count: got %0d want %0d", name, sv_data.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < sv_data.size() && i < rd_cyc.size(); i++) begin
      n_tests++;
      if (sv_cyc[i] != rd_cyc[i] + LAT || sv_data[i] !== mem_word(exp[i])) begin
        n_fail++;
        $display("FAIL %s sample[%0d]: got data %h at +%0d want %h at +%0d",
                 name, i, sv_data[i], sv_cyc[i] - rd_cyc[i], mem_word(exp[i]), LAT);
      end
    end
    n_tests++;
    if (done_cyc.size() != (edone ? 1 : 0)) begin
      n_fail++; $display("FAIL %s done_count: got %0d want %0d", name, done_cyc.size(), edone ? 1 : 0);
    end
    if (edone && done_cyc.size() == 1 && sv_cyc.size() > 0) begin
      n_tests++;
      if (done_cyc[0] != sv_cyc[sv_cyc.size() - 1] || busy_log[done_cyc[0]] !== 1'b1 ||
          busy_log[done_cyc[0] + 1] !== 1'b0) begin
        n_fail++;
        $display("FAIL %s done_timing: done@%0d last_valid@%0d busy %0b->%0b want same cycle, 1->0",
                 name, done_cyc[0], sv_cyc[sv_cyc.size() - 1], busy_log[done_cyc[0]], busy_log[done_cyc[0] + 1]);
      end
    end
    n_tests++;
    if (ovr_cyc.size() != 0) begin
      n_fail++; $display("FAIL %s overrun_count: got %0d want 0", name, ovr_cyc.size());
    end
    n_tests++;
    if (busy !== !edone) begin
      n_fail++; $display("FAIL %s busy_end: got %0b want %0b", name, busy, !edone);
    end
    stop = 1'b1; cyc(); stop = 1'b0; cyc();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy_after_stop: got %0b want 0", name, busy);
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    cyc(2);
    n_tests++;
    if ({mif.mem_address, mif.mem_read, sample_out, sample_valid, busy, done, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: addr %h rd %b out %h sv %b busy %b done %b ovr %b want all 0",
               mif.mem_address, mif.mem_read, sample_out, sample_valid, busy, done, overrun);
    end
    reset_n = 1'b1;
    clear_log();
    cyc(2);
    pulse_tick();
    cyc(3);
    n_tests++;
    if (busy !== 1'b0 || rd_addr.size() != 0 || ovr_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL idle_tick: busy %b fetches %0d overruns %0d want 0 0 0", busy, rd_addr.size(), ovr_cyc.size());
    end
  endtask

  task automatic test_single_run();
    test_playback("single", 15'h0010, 15'h0012, 1'b0, 4, 8);
  endtask

  task automatic test_loop();
    test_playback("loop", 15'h0010, 15'h0012, 1'b1, 7, 8);
  endtask

  task automatic test_wrap();
    test_playback("wrap_single", 15'h7FFF, 15'h0001, 1'b0, 3, 5);
    test_playback("wrap_pair", 15'h7FFE, 15'h7FFF, 1'b0, 3, 5);
  endtask

  task automatic test_overrun();
    addr_q_t exp;
    bit      edone;
    int      t_ov;
    exp = exp_seq(15'h0020, 15'h0022, 1'b0, 3, edone);
    clear_log();
    start_addr = 15'h0020; end_addr = 15'h0022; loop_en = 1'b0;
    go = 1'b1; cyc(); go = 1'b0;
    cyc(2);
    start_addr = 15'h0100; end_addr = 15'h0105;
    go = 1'b1; cyc(); go = 1'b0;
    pulse_tick();
    cyc();
    t_ov = pc;
    pulse_tick();
    for (int i = 0; i < 2; i++) begin
      cyc(4);
      pulse_tick();
    end
    cyc(6);
    n_tests++;
    if (ovr_cyc.size() != 1 || (ovr_cyc.size() == 1 && ovr_cyc[0] != t_ov + 1)) begin
      n_fail++;
      $display("FAIL overrun_pulse: got %0d pulses first@%0d want 1 pulse @%0d",
               ovr_cyc.size(), (ovr_cyc.size() > 0) ? ovr_cyc[0] : -1, t_ov + 1);
    end
    n_tests++;
    if (rd_addr.size() != exp.size()) begin
      n_fail++; $display("FAIL overrun fetch_count: got %0d want %0d", rd_addr.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        n_tests++;
        if (rd_addr[i] !== exp[i]) begin
          n_fail++; $display("FAIL overrun addr[%0d]: got %h want %h", i, rd_addr[i], exp[i]);
        end
      end
    end
    n_tests++;
    if (done_cyc.size() != 1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL overrun completion: done %0d busy %b want 1 0", done_cyc.size(), busy);
    end
  endtask

  task automatic test_stop();
    logic [DW-1:0] held;
    start_addr = 15'h0040; end_addr = 15'h0045; loop_en = 1'b0;
    go = 1'b1; cyc(); go = 1'b0;
    cyc(2);
    pulse_tick();
    cyc(5);
    held = mem_word(15'h0040);
    n_tests++;
    if (sample_out !== held) begin
      n_fail++; $display("FAIL stop first_sample: got %h want %h", sample_out, held);
    end
    clear_log();
    pulse_tick();
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL stop busy_next: got %b want 0", busy);
    end
    cyc(4);
    pulse_tick();
    cyc(4);
    n_tests++;
    if (sv_cyc.size() != 0 || done_cyc.size() != 0 || ovr_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL stop pulses: valid %0d done %0d overrun %0d want 0 0 0",
               sv_cyc.size(), done_cyc.size(), ovr_cyc.size());
    end
    n_tests++;
    if (sample_out !== held) begin
      n_fail++; $display("FAIL stop sample_held: got %h want %h", sample_out, held);
    end
    n_tests++;
    if (rd_addr.size() != 1 || (rd_addr.size() == 1 && rd_addr[0] !== 15'h0041)) begin
      n_fail++;
      $display("FAIL stop fetches: got %0d first %h want 1 at 0041",
               rd_addr.size(), (rd_addr.size() > 0) ? rd_addr[0] : '0);
    end
  endtask

  task automatic test_reset_mid();
    start_addr = 15'h0055; end_addr = 15'h0058; loop_en = 1'b0;
    go = 1'b1; cyc(); go = 1'b0;
    cyc(2);
    pulse_tick();
    cyc();
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({mif.mem_address, mif.mem_read, sample_out, sample_valid, busy, done, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid outputs: addr %h rd %b out %h sv %b busy %b done %b ovr %b want all 0",
               mif.mem_address, mif.mem_read, sample_out, sample_valid, busy, done, overrun);
    end
    cyc(2);
    reset_n = 1'b1;
    clear_log();
    cyc(2);
    pulse_tick();
    cyc(4);
    n_tests++;
    if (busy !== 1'b0 || rd_addr.size() != 0 || sv_cyc.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid idle: busy %b fetches %0d valids %0d want 0 0 0",
               busy, rd_addr.size(), sv_cyc.size());
    end
    test_playback("post_reset", 15'h0123, 15'h0125, 1'b0, 3, 5);
  endtask

  task automatic test_random();
    logic [AW-1:0] s;
    logic [AW-1:0] e;
    for (int it = 0; it < 8; it++) begin
      salt = DW'($urandom);
      s    = AW'($urandom);
      if ($urandom_range(0, 3) == 0) e = s - AW'($urandom_range(1, 20));
      else                           e = s + AW'($urandom_range(0, 4));
      test_playback("random", s, e, 1'($urandom_range(0, 1)), int'($urandom_range(1, 7)),
                    int'($urandom_range(4, 9)));
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_loop();
    test_overrun();
    test_stop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
